// File: rtl/wb_arbiter2_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: FSM encodings,
// default watchdog limit and a grant encoding helper.
package wb_arbiter2_pkg;

    localparam int unsigned TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT0  = 2'd1,
        GNT1  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // One-hot grant vector for master index sel.
    function automatic logic [1:0] gnt_onehot(input logic sel);
        return sel ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/wb_arb_timer.sv
// Watchdog counter: counts cycles while run_i is high and flags expiry at TIMEOUT-1.
module wb_arb_timer
    import wb_arbiter2_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic run_i,
    output logic expire_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;

    // Saturates at LIMIT so a held expiry never wraps back to zero.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else if (run_i && (cnt_q != LIMIT)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expire_o = run_i && !clr_i && (cnt_q == LIMIT);

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master round-robin arbiter for a pipelined Wishbone register bus.
// Optional watchdog with DRAIN state when WB_ARB_TIMEOUT_EN is defined.
module wb_arbiter2
    import wb_arbiter2_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned ADDR  = 7
`ifdef WB_ARB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
`endif
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic             m0_cyc_i,
    input  logic             m0_stb_i,
    input  logic             m0_we_i,
    input  logic [ADDR-1:0]  m0_adr_i,
    input  logic [WIDTH-1:0] m0_dat_i,
    output logic             m0_ack_o,
    output logic             m0_rty_o,
    output logic             m0_err_o,
    output logic             m0_wat_o,
    output logic [WIDTH-1:0] m0_dat_o,

    input  logic             m1_cyc_i,
    input  logic             m1_stb_i,
    input  logic             m1_we_i,
    input  logic [ADDR-1:0]  m1_adr_i,
    input  logic [WIDTH-1:0] m1_dat_i,
    output logic             m1_ack_o,
    output logic             m1_rty_o,
    output logic             m1_err_o,
    output logic             m1_wat_o,
    output logic [WIDTH-1:0] m1_dat_o,

    output logic             s_cyc_o,
    output logic             s_stb_o,
    output logic             s_we_o,
    output logic [ADDR-1:0]  s_adr_o,
    output logic [WIDTH-1:0] s_dat_o,
    input  logic             s_ack_i,
    input  logic             s_wat_i,
    input  logic             s_rty_i,
    input  logic             s_err_i,
    input  logic [WIDTH-1:0] s_dat_i,

    output logic [1:0]       gnt_o
);

    state_t     state_q, state_d;
    logic       last_q, last_d;
    logic [1:0] gnt_q, gnt_d;
    logic       wd_err;

`ifdef WB_ARB_TIMEOUT_EN
    logic tmr_clr;

    // Counter is held at zero while idle, so it starts fresh on every grant.
    assign tmr_clr = s_ack_i | s_rty_i | s_err_i | (state_q == IDLE);

    wb_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (tmr_clr),
        .run_i    (s_cyc_o),
        .expire_o (wd_err)
    );
`else
    assign wd_err = 1'b0;
`endif

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign gnt_o    = gnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            gnt_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
        end
    end

    // Next-state logic and the combinational request/response routing.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        gnt_d    = gnt_q;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_wat_o = m0_cyc_i;
        m1_wat_o = m1_cyc_i;
        m0_ack_o = 1'b0;
        m0_rty_o = 1'b0;
        m0_err_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_rty_o = 1'b0;
        m1_err_o = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
                    state_d = GNT0;
                    last_d  = 1'b0;
                    gnt_d   = gnt_onehot(1'b0);
                end else if (m1_cyc_i) begin
                    state_d = GNT1;
                    last_d  = 1'b1;
                    gnt_d   = gnt_onehot(1'b1);
                end
            end
            GNT0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                m0_wat_o = s_wat_i;
                m0_ack_o = s_ack_i;
                m0_rty_o = s_rty_i;
                m0_err_o = s_err_i | wd_err;
                if (!m0_cyc_i) begin
                    state_d = IDLE;
                    gnt_d   = 2'b00;
                end
`ifdef WB_ARB_TIMEOUT_EN
                else if (wd_err) begin
                    state_d = DRAIN;
                end
`endif
            end
            GNT1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                m1_wat_o = s_wat_i;
                m1_ack_o = s_ack_i;
                m1_rty_o = s_rty_i;
                m1_err_o = s_err_i | wd_err;
                if (!m1_cyc_i) begin
                    state_d = IDLE;
                    gnt_d   = 2'b00;
                end
`ifdef WB_ARB_TIMEOUT_EN
                else if (wd_err) begin
                    state_d = DRAIN;
                end
`endif
            end
`ifdef WB_ARB_TIMEOUT_EN
            // Slave is cut off; wait for the timed-out owner to release its cycle.
            DRAIN: begin
                if (!(last_q ? m1_cyc_i : m0_cyc_i)) begin
                    state_d = IDLE;
                    gnt_d   = 2'b00;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

endmodule
